// File: rtl/serial_subtractor.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : serial_subtractor
// Brief    : Bit-serial unsigned subtractor, diff = a - b, LSB first, one bit
//            per clock. Each bit goes through two cascaded half-subtractor
//            stages; the borrow between bits is held in a single flop.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
);

   // Counter must be able to index every bit position of the operands.
   localparam int                  c_CNT_W = $clog2(WIDTH + 1);
   localparam logic [c_CNT_W-1:0]  c_LAST  = c_CNT_W'(WIDTH - 1);
   localparam logic [c_CNT_W-1:0]  c_ONE   = c_CNT_W'(1);

   localparam logic [1:0] c_IDLE  = 2'b00;
   localparam logic [1:0] c_SHIFT = 2'b01;
   localparam logic [1:0] c_DONE  = 2'b10;

   logic [1:0]         r_state;
   logic [1:0]         w_state_nxt;
   logic               r_busy;
   logic               r_done;
   logic               w_busy_nxt;
   logic               w_done_nxt;

   logic [WIDTH-1:0]   r_a_sh;
   logic [WIDTH-1:0]   r_b_sh;
   logic               r_br;
   logic [c_CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0]   r_diff;
   logic               r_borrow_out;

   logic               w_shift_en;
   logic               w_last;
   logic               w_d1;
   logic               w_b1;
   logic               w_d;
   logic               w_b2;
   logic               w_br_nxt;
   logic [WIDTH-1:0]   w_res_final;

   assign w_shift_en = (r_state == c_SHIFT);
   assign w_last     = (r_cnt == c_LAST);

   // Per-bit datapath: two half-subtractor stages, borrow-in from the flop.
   always_comb begin
      w_d1     = r_a_sh[0] ^ r_b_sh[0];
      w_b1     = ~r_a_sh[0] & r_b_sh[0];
      w_d      = w_d1 ^ r_br;
      w_b2     = ~w_d1 & r_br;
      w_br_nxt = w_b1 | w_b2;
   end

   // Result shifter. Only WIDTH-1 bits are stored: the bit produced on the
   // final SHIFT cycle goes straight into diff together with the stored bits.
   generate
      if (WIDTH == 1) begin : g_res_w1
         assign w_res_final = w_d;
      end else if (WIDTH == 2) begin : g_res_w2
         logic r_res_sh;

         // Hold the first result bit until the last bit arrives.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_res_sh <= 1'b0;
            end else if (w_shift_en) begin
               r_res_sh <= w_d;
            end
         end

         assign w_res_final = {w_d, r_res_sh};
      end else begin : g_res_wn
         logic [WIDTH-2:0] r_res_sh;

         // Shift right, new bit enters at the MSB.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_res_sh <= '0;
            end else if (w_shift_en) begin
               r_res_sh <= {w_d, r_res_sh[WIDTH-2:1]};
            end
         end

         assign w_res_final = {w_d, r_res_sh};
      end
   endgenerate

   // State register with registered status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
      end
   end

   // Next-state logic; DONE always returns to IDLE so start is re-sampled.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_IDLE:  if (start)  w_state_nxt = c_SHIFT;
         c_SHIFT: if (w_last) w_state_nxt = c_DONE;
         c_DONE:  w_state_nxt = c_IDLE;
         default: w_state_nxt = c_IDLE;
      endcase
   end

   // Output decode from the next state so busy/done come straight off flops.
   always_comb begin
      w_busy_nxt = (w_state_nxt == c_SHIFT);
      w_done_nxt = (w_state_nxt == c_DONE);
   end

   // Operand shifters, borrow flop, bit counter and result capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a_sh       <= '0;
         r_b_sh       <= '0;
         r_br         <= 1'b0;
         r_cnt        <= '0;
         r_diff       <= '0;
         r_borrow_out <= 1'b0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (start) begin
                  r_a_sh <= a;
                  r_b_sh <= b;
                  r_br   <= 1'b0;
                  r_cnt  <= '0;
               end
            end
            c_SHIFT: begin
               r_a_sh <= r_a_sh >> 1;
               r_b_sh <= r_b_sh >> 1;
               r_br   <= w_br_nxt;
               r_cnt  <= r_cnt + c_ONE;
               if (w_last) begin
                  r_diff       <= w_res_final;
                  r_borrow_out <= w_br_nxt;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign busy       = r_busy;
   assign done       = r_done;
   assign diff       = r_diff;
   assign borrow_out = r_borrow_out;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
`timescale 1ns/1ps
//------------------------------------------------------------------------------
// Module   : tb_serial_subtractor
// Brief    : Directed bench for serial_subtractor (WIDTH=8 and WIDTH=1) with
//            a queue-based scoreboard of expected {borrow, diff} results.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_serial_subtractor;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start8, start1;
   logic [7:0] a8, b8;
   logic       a1, b1;
   logic       busy8, done8, borrow8;
   logic [7:0] diff8;
   logic       busy1, done1, borrow1;
   logic       diff1;

   int         n_checks  = 0;
   int         n_errors  = 0;
   int         cyc       = 0;
   int         done8_cnt = 0;
   int         done8_cyc[$];
   logic [8:0] q8[$];
   logic [1:0] q1[$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   serial_subtractor #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .diff(diff8), .borrow_out(borrow8)
   );

   serial_subtractor #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
      .busy(busy1), .done(done1), .diff(diff1), .borrow_out(borrow1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard for the 8-bit instance: every done pops one expected result.
   always @(negedge clk) begin : mon8
      logic [8:0] e;
      if (done8 === 1'b1) begin
         done8_cnt++;
         done8_cyc.push_back(cyc);
         chk("done8_expected", 32'(q8.size() != 0), 1);
         if (q8.size() != 0) begin
            e = q8.pop_front();
            chk("diff8", diff8, e[7:0]);
            chk("borrow8", borrow8, e[8]);
            chk("busy8_at_done", busy8, 0);
         end
      end
   end

   // Scoreboard for the 1-bit instance.
   always @(negedge clk) begin : mon1
      logic [1:0] e;
      if (done1 === 1'b1) begin
         chk("done1_expected", 32'(q1.size() != 0), 1);
         if (q1.size() != 0) begin
            e = q1.pop_front();
            chk("diff1", diff1, e[0]);
            chk("borrow1", borrow1, e[1]);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: observed no finish expected finish");
      $fatal(1, "global timeout");
   end

   task automatic wait_done8(input string tag);
      int k = 0;
      while (done8 !== 1'b1 && k < 40) begin
         @(negedge clk);
         k++;
      end
      chk({tag, "_done_seen"}, done8, 1);
   endtask

   // Called on a negedge with the 8-bit DUT idle; returns on a negedge idle.
   task automatic op8(input logic [7:0] a, input logic [7:0] b, input string tag);
      a8 = a; b8 = b; start8 = 1'b1;
      q8.push_back({1'b0, a} - {1'b0, b});
      @(negedge clk);
      start8 = 1'b0;
      wait_done8(tag);
      @(negedge clk);
   endtask

   initial begin
      int base;
      rst_n = 1'b0; start8 = 1'b0; start1 = 1'b0;
      a8 = '0; b8 = '0; a1 = 1'b0; b1 = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy8", busy8, 0);
      chk("rst_done8", done8, 0);
      chk("rst_diff8", diff8, 0);
      chk("rst_borrow8", borrow8, 0);
      chk("rst_busy1", busy1, 0);
      chk("rst_diff1", diff1, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // 5 - 3: busy for exactly 8 cycles, then a single done.
      a8 = 8'd5; b8 = 8'd3; start8 = 1'b1;
      q8.push_back(9'd2);
      @(negedge clk);
      start8 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("lat_busy8", busy8, 1);
         chk("lat_nodone8", done8, 0);
         @(negedge clk);
      end
      chk("lat_done8", done8, 1);
      chk("lat_busy8_low", busy8, 0);
      @(negedge clk);
      chk("done8_single", done8, 0);

      op8(8'd3,  8'd5,  "op_3_5");
      chk("hold_diff_fe", diff8, 8'hFE);
      op8(8'h00, 8'hFF, "op_00_ff");
      op8(8'hA5, 8'hA5, "op_a5_a5");

      // Start re-pulsed during SHIFT and during DONE must be ignored.
      a8 = 8'd5; b8 = 8'd3; start8 = 1'b1;
      q8.push_back(9'd2);
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      a8 = 8'd9; b8 = 8'd1; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      base = done8_cnt;
      wait_done8("ignore");
      a8 = 8'd9; b8 = 8'd1; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      chk("ignore_pulse_len", done8, 0);
      repeat (12) @(negedge clk);
      chk("ignore_one_done", done8_cnt - base, 1);
      chk("ignore_diff_hold", diff8, 8'h02);
      chk("ignore_busy_idle", busy8, 0);

      // Reset in the 4th SHIFT cycle aborts the operation.
      base = done8_cnt;
      a8 = 8'hF0; b8 = 8'h0F; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort_busy_before", busy8, 1);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", busy8, 0);
      chk("abort_done", done8, 0);
      chk("abort_diff", diff8, 0);
      chk("abort_borrow", borrow8, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      chk("abort_no_done", done8_cnt - base, 0);
      op8(8'hF0, 8'h0F, "op_f0_0f");
      chk("after_abort_diff", diff8, 8'hE1);

      // Start held high: one completion every WIDTH+2 cycles.
      base = done8_cyc.size();
      for (int i = 0; i < 4; i++) q8.push_back(9'd6);
      a8 = 8'd10; b8 = 8'd4; start8 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         wait_done8("cont");
      end
      @(negedge clk);
      start8 = 1'b0;
      repeat (15) @(negedge clk);
      for (int i = 1; i < 4; i++)
         chk("cont_period", done8_cyc[base+i] - done8_cyc[base+i-1], 10);
      chk("cont_queue_empty", q8.size(), 0);

      // WIDTH=1 truth table: done on the second edge after accept.
      for (int i = 0; i < 4; i++) begin
         logic [1:0] ab;
         ab = i[1:0];
         a1 = ab[1]; b1 = ab[0]; start1 = 1'b1;
         q1.push_back({1'b0, ab[1]} - {1'b0, ab[0]});
         @(negedge clk);
         start1 = 1'b0;
         chk("w1_busy", busy1, 1);
         chk("w1_nodone", done1, 0);
         @(negedge clk);
         chk("w1_done", done1, 1);
         chk("w1_busy_low", busy1, 0);
         @(negedge clk);
         chk("w1_done_single", done1, 0);
      end
      chk("w1_queue_empty", q1.size(), 0);
      chk("w8_queue_empty", q8.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
